reg_file_seq: RTL and testbench

Bulk-access sequencer that drives the 3-port register file (two combinational read ports, one clocked write port) on behalf of a simple command interface. It executes DUMP (read a range of registers out as a valid/ready stream), LOAD (write a valid/ready input stream into a range of registers) and CLEAR (zero a range of registers). It sits between a host/debug controller and `reg_file`, acting as the initiator on the register-file port.

---
 rtl/reg_file_seq_pkg.sv | 33 +++
 rtl/reg_file_seq_if.sv | 39 +++
 rtl/rf_seq_ptr.sv | 35 +++
 rtl/reg_file_seq.sv | 118 +++++++++++
 tb/tb_reg_file_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_seq_pkg.sv
// Shared definitions for the register-file bulk-access sequencer.
package reg_file_seq_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned CW       = 6;
  localparam int unsigned CNT_MAX  = 32;

  typedef enum logic [1:0] {
    OP_DUMP  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMP_RD,
    S_DUMP_EMIT0,
    S_DUMP_EMIT1,
    S_LOAD,
    S_CLEAR,
    S_DONE
  } state_e;

  // Reserved op behaves as an empty command; larger counts saturate at a full sweep.
  function automatic logic [CW-1:0] clamp_count(input logic [1:0] op, input logic [CW-1:0] count);
    if (op == OP_RSVD) return '0;
    return (count > CW'(CNT_MAX)) ? CW'(CNT_MAX) : count;
  endfunction

endpackage

// File: rtl/reg_file_seq_if.sv
// Command, stream and register-file port bundle for reg_file_seq.
interface reg_file_seq_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_base;
  logic [5:0]    cmd_count;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] rf_A1;
  logic [AW-1:0] rf_A2;
  logic [AW-1:0] rf_A3;
  logic [DW-1:0] rf_WD3;
  logic          rf_WE3;
  logic [DW-1:0] rf_RD1;
  logic [DW-1:0] rf_RD2;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_count, in_valid, in_data, out_ready, rf_RD1, rf_RD2,
    input  cmd_ready, in_ready, out_valid, out_data, out_addr,
           rf_A1, rf_A2, rf_A3, rf_WD3, rf_WE3, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_count, in_valid, in_data, out_ready, rf_RD1, rf_RD2,
    output cmd_ready, in_ready, out_valid, out_data, out_addr,
           rf_A1, rf_A2, rf_A3, rf_WD3, rf_WE3, busy, done
  );
endinterface

// File: rtl/rf_seq_ptr.sv
// Wrapping register pointer plus remaining-access down-counter.
module rf_seq_ptr
  import reg_file_seq_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] count,
  output logic [AW-1:0] ptr,
  output logic [AW-1:0] ptr_nxt,
  output logic          last
);
  logic [CW-1:0] rem;

  assign ptr_nxt = (ptr == AW'(NREG - 1)) ? '0 : ptr + AW'(1);
  assign last    = (rem == CW'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      rem <= '0;
    end else if (load) begin
      ptr <= base;
      rem <= count;
    end else if (step) begin
      ptr <= ptr_nxt;
      rem <= rem - CW'(1);
    end
  end
endmodule

// File: rtl/reg_file_seq.sv
// Bulk DUMP/LOAD/CLEAR sequencer driving a 2-read/1-write register file.
module reg_file_seq
  import reg_file_seq_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input logic           clock,
  input logic           reset,
  reg_file_seq_if.slave bus
);
  state_e        state;
  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [CW-1:0] cnt_eff;
  logic          last;
  logic          accept;
  logic          step;

  assign accept  = (state == S_IDLE) && bus.cmd_valid;
  assign cnt_eff = clamp_count(bus.cmd_op, bus.cmd_count);
  assign step    = (((state == S_DUMP_EMIT0) || (state == S_DUMP_EMIT1)) && bus.out_ready)
                || ((state == S_LOAD) && bus.in_valid)
                ||  (state == S_CLEAR);

  rf_seq_ptr #(.NREG(NREG), .AW(AW)) u_ptr (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .step    (step),
    .base    (bus.cmd_base),
    .count   (cnt_eff),
    .ptr     (ptr),
    .ptr_nxt (ptr_nxt),
    .last    (last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.cmd_valid) begin
            if (cnt_eff == '0) state <= S_DONE;
            else begin
              case (op_e'(bus.cmd_op))
                OP_DUMP:  state <= S_DUMP_RD;
                OP_LOAD:  state <= S_LOAD;
                OP_CLEAR: state <= S_CLEAR;
                default:  state <= S_DONE;
              endcase
            end
          end
        S_DUMP_RD: begin
          buf0  <= bus.rf_RD1;
          buf1  <= bus.rf_RD2;
          state <= S_DUMP_EMIT0;
        end
        S_DUMP_EMIT0: if (bus.out_ready) state <= last ? S_DONE : S_DUMP_EMIT1;
        S_DUMP_EMIT1: if (bus.out_ready) state <= last ? S_DONE : S_DUMP_RD;
        S_LOAD:       if (bus.in_valid && last) state <= S_DONE;
        S_CLEAR:      if (last) state <= S_DONE;
        default:      state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset kills rf_WE3 at once.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_addr  = '0;
    bus.rf_A1     = '0;
    bus.rf_A2     = '0;
    bus.rf_A3     = '0;
    bus.rf_WD3    = '0;
    bus.rf_WE3    = 1'b0;
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    case (state)
      S_IDLE:    bus.cmd_ready = reset;
      S_DUMP_RD: begin
        bus.rf_A1 = ptr;
        bus.rf_A2 = ptr_nxt;
      end
      S_DUMP_EMIT0: begin
        bus.out_valid = 1'b1;
        bus.out_data  = buf0;
        bus.out_addr  = ptr;
      end
      S_DUMP_EMIT1: begin
        bus.out_valid = 1'b1;
        bus.out_data  = buf1;
        bus.out_addr  = ptr;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.rf_WE3   = bus.in_valid;
        bus.rf_A3    = ptr;
        bus.rf_WD3   = bus.in_data;
      end
      S_CLEAR: begin
        bus.rf_WE3 = 1'b1;
        bus.rf_A3  = ptr;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_reg_file_seq.sv
// Bench for reg_file_seq: behavioural register file, command table and beat scoreboard.
module tb_reg_file_seq;
  typedef struct packed {
    logic [1:0]       op;
    logic [4:0]       base;
    logic [5:0]       count;
    logic [1:0]       mode;
    logic [3:0][31:0] d;
    logic [6:0]       exp_we;
  } vec_t;

  logic clock;
  logic reset;
  logic preload;
  logic [31:0] regs [32];
  logic [31:0] exp_regs [32];
  logic [36:0] exp_q [$];
  bit   [3:0]  pat = 4'b1001;
  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs [14];

  reg_file_seq_if #(.AW(5), .DW(32)) bus ();

  reg_file_seq #(.NREG(32), .AW(5), .DW(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000 + 32'(i);
    end else if (bus.rf_WE3) begin
      regs[bus.rf_A3] <= bus.rf_WD3;
    end
  end
  assign bus.rf_RD1 = regs[bus.rf_A1];
  assign bus.rf_RD2 = regs[bus.rf_A2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_regs(input string name);
    int mism = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== exp_regs[i]) mism++;
    check(name, 64'(mism), 64'd0);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int base, input int count, input int mode,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input int we);
    vec_t v;
    v.op = op; v.base = 5'(base); v.count = 6'(count); v.mode = 2'(mode);
    v.d = {d3, d2, d1, d0}; v.exp_we = 7'(we);
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n, li, last_act, done_k, we_cnt;
    bit got, stalled;
    logic [4:0]  a, held_a;
    logic [31:0] held_d;
    logic [36:0] exp_beat;
    n = (v.op == 2'b11) ? 0 : ((v.count > 6'd32) ? 32 : int'(v.count));
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(v.base) + i) % 32);
      case (v.op)
        2'b00:   exp_q.push_back({a, exp_regs[a]});
        2'b01:   exp_regs[a] = v.d[i];
        2'b10:   exp_regs[a] = '0;
        default: ;
      endcase
    end
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = v.op; bus.cmd_base = v.base; bus.cmd_count = v.count;
    @(negedge clock);
    check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    li = 0; last_act = -1; done_k = -100; we_cnt = 0; got = 0; stalled = 0;
    held_a = '0; held_d = '0;
    for (int k = 0; k < 300 && !got; k++) begin
      bus.out_ready = (v.mode == 2'd0) ? 1'b1 : pat[k % 4];
      if (v.op == 2'b01 && li < n) begin
        bus.in_valid = (v.mode == 2'd0) ? 1'b1 : pat[k % 4];
        bus.in_data  = v.d[li];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
      end
      @(negedge clock);
      if (k == 0) check("busy", 64'(bus.busy), 64'd1);
      if (bus.rf_WE3) begin we_cnt++; last_act = k; end
      if (stalled)
        check("out_hold", 64'({bus.out_valid, bus.out_addr, bus.out_data}), 64'({1'b1, held_a, held_d}));
      stalled = 0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          exp_beat = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          check("beat", 64'({bus.out_addr, bus.out_data}), 64'(exp_beat));
          last_act = k;
        end else begin
          stalled = 1; held_a = bus.out_addr; held_d = bus.out_data;
        end
      end
      if (bus.in_valid && bus.in_ready) li++;
      if (bus.done) begin got = 1; done_k = k; end
      else begin @(posedge clock); #1; end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    check("done_timing", 64'(done_k), 64'(last_act + 1));
    check("we_count", 64'(we_cnt), 64'(v.exp_we));
    check("beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clock);
    check("idle_after", 64'({bus.done, bus.busy, bus.cmd_ready}), 64'(3'b001));
    check_regs("regs");
  endtask

  initial begin
    reset = 1'b0; preload = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_base = '0; bus.cmd_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h1000 + 32'(i);

    vecs[0]  = mk(2'b01,  2,  3, 0, 32'd35, 32'd45, 32'd55, 32'd0, 3);
    vecs[1]  = mk(2'b00,  2,  3, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(2'b00,  0,  6, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(2'b01, 31,  2, 1, 32'd7, 32'd9, 0, 0, 2);
    vecs[4]  = mk(2'b00, 31,  2, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(2'b00, 30,  3, 1, 0, 0, 0, 0, 0);
    vecs[6]  = mk(2'b01, 29,  4, 1, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004, 4);
    vecs[7]  = mk(2'b00, 28,  5, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(2'b10,  0, 40, 0, 0, 0, 0, 0, 32);
    vecs[9]  = mk(2'b00,  7, 32, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(2'b00,  3,  0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(2'b11,  4,  5, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(2'b01, 14,  4, 0, 32'h0BEEF001, 32'h0BEEF002, 32'h0BEEF003, 32'h0BEEF004, 4);
    vecs[13] = mk(2'b00, 13,  6, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outs", 64'({bus.cmd_ready, bus.busy, bus.done, bus.rf_WE3, bus.out_valid, bus.in_ready}), 64'd0);
    preload = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    check("post_reset", 64'({bus.cmd_ready, bus.busy, bus.done, bus.rf_WE3, bus.out_valid, bus.in_ready}),
          64'(6'b100000));
    check_regs("preload");

    for (int v = 0; v < 14; v++) run_vec(vecs[v]);

    // Reset lands right after the first LOAD write has been committed.
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_base = 5'd10; bus.cmd_count = 6'd3;
    @(negedge clock);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h000000A1;
    @(negedge clock);
    check("rst_we_before", 64'(bus.rf_WE3), 64'd1);
    @(posedge clock); #1;
    bus.in_data = 32'h000000A2;
    reset = 1'b0;
    #1;
    check("rst_we_drop", 64'({bus.rf_WE3, bus.busy, bus.cmd_ready}), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; bus.in_valid = 1'b0;
    @(negedge clock);
    check("rst_idle", 64'({bus.cmd_ready, bus.busy, bus.done, bus.rf_WE3}), 64'(4'b1000));
    exp_regs[10] = 32'h000000A1;
    check_regs("rst_regs");
    run_vec(mk(2'b00, 9, 5, 1, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
